tlp_host_bfm: RTL and testbench
===============================

Name: tlp_host_bfm

Overview:
- Synthesizable host-side TLP initiator. It plays the CPU/root-complex end of the 64-bit Avalon-ST TLP link into tlp_xcvr.
- Converts simple register write/read commands into MWr32/MRd32 TLPs on tlp_xcvr's rx side.
- Parses CplD TLPs returned on tlp_xcvr's tx side and presents read data.
- Used in system benches and in on-chip loopback self-test builds.

Parameters:
- REQ_ID, 16'h0100, requester ID placed in request headers and checked in completions.
- BAR_BASE, 32'h0000_0000, BAR0 base address. Register address = BAR_BASE + chan*8.
- TIMEOUT, 1024, cycles to wait for a completion before flagging an error. Must be ≥2.

Ports:
- pcieClk_in  in  1  core clock
- reset_in  in  1  asynchronous reset, active-high
- cmdWrite_in  in  1  1 = register write, 0 = register read
- cmdChan_in  in  tlp_xcvr_pkg::Channel  register channel
- cmdData_in  in  32  write data
- cmdValid_in  in  1  command valid
- cmdReady_out  out  1  command accepted when valid & ready
- rspData_out  out  32  read data
- rspErr_out  out  1  qualifies rspValid: timeout occurred
- rspValid_out  out  1  single-cycle read-response strobe
- txData_out  out  64  TLP beats to tlp_xcvr rxData_in
- txValid_out  out  1  beat valid
- txReady_in  in  1  beat accepted when valid & ready
- txSOP_out  out  tlp_xcvr_pkg::SopBar  BAR0 SOP encoding on first beat, zero otherwise
- txEOP_out  out  1  last beat
- rxData_in  in  64  TLP beats from tlp_xcvr txData_out
- rxValid_in  in  1  beat valid
- rxReady_out  out  1  always 1 after reset (completion sink never stalls)
- rxSOP_in  in  1  first beat
- rxEOP_in  in  1  last beat

Behaviour:
Reset:
- All outputs are 0 except rxReady_out, which is 1 one cycle after reset deasserts.
- Tag counter is 0.
- Both FSMs are idle.
- Reset mid-TLP abandons the packet immediately. No EOP is emitted.

Request FSM states: IDLE, WR0, WR1, WR2, RD0, RD1, WAIT.
- IDLE: cmdReady_out=1. On accept, latch the command and go to WR0 or RD0.
  - Accept→first beat valid latency is 1 cycle.
- Each beat holds data, valid, SOP and EOP stable until txReady_in. Advance only on handshake. No bubbles are required between beats.
- Header fields:
  - MWr DW0 = 32'h4000_0001.
  - MRd DW0 = 32'h0000_0001.
  - DW1 = {REQ_ID, tag[7:0], 4'h0, 4'hF}.
  - DW2 = BAR_BASE + {chan, 3'b000}, with bits[2:0] = 0, i.e. QW-aligned.
- Write beats:
  - WR0 = {DW1, DW0} with SOP.
  - WR1 = {32'h0, DW2}.
  - WR2 = {32'h0, data} with EOP.
  - After WR2 handshake go to IDLE. Writes are posted: no response.
  - Write tag = current tag; the counter is not incremented.
- Read beats:
  - RD0 = {DW1, DW0} with SOP.
  - RD1 = {32'h0, DW2} with EOP.
  - After RD1 handshake go to WAIT and increment the 5-bit tag (tag[7:5]=0). The tag wraps 31→0.
- WAIT:
  - cmdReady_out=0. Only one read is outstanding.
  - Timer counts from 0.
  - On matching completion data: rspValid_out=1 for one cycle with data, rspErr_out=0, then IDLE.
  - If timer reaches TIMEOUT-1 with no match: rspValid_out=1, rspErr_out=1, rspData_out=32'hDEAD_DEAD, then IDLE.
  - If a completion and timeout land in the same cycle, the completion wins.

Completion parser states: C0, C1, C2, CDROP. It runs in parallel and sees every beat with rxValid_in.
- C0:
  - Requires rxSOP_in.
  - Accepts the TLP only if DW0[31:24] = 8'h4A (CplD), DW0[9:0] = 1, and DW1[15:13] = 3'b000 (status SC).
  - Otherwise go to CDROP until rxEOP_in.
- C1:
  - Requires DW2[31:16] = REQ_ID and DW2[15:8] = the outstanding tag, with the FSM in WAIT.
  - If lower-address bit 2 is 1: data = rxData_in[63:32], which must carry EOP. Match resolves here.
  - Else go to C2: data = rxData_in[31:0] on the next beat, which carries EOP.
- Any mismatch, or a completion arriving outside WAIT, is silently dropped; drain to EOP.
- Non-SOP beat while in C0: ignored.
- rxSOP_in mid-packet: restart parsing at C0 on that beat.

Test Plan:
- Write chan 3, data 32'h1234_5678, txReady_in=1 → three beats:
  - 64'h0100_000F_4000_0001 with SOP
  - 64'h0000_0000_0000_0018
  - 64'h0000_0000_1234_5678 with EOP
  - then cmdReady_out=1.
- Read chan 5, tag 0 → two beats: 64'h0100_000F_0000_0001 with SOP, then 64'h0000_0000_0000_0028 with EOP. Then inject CplD with DW2 = 32'h0100_0028 and data beat 32'hCAFE_F00D → rspValid_out for one cycle with 32'hCAFE_F00D, rspErr_out=0. Next read carries tag 1.
- txReady_in toggled randomly during a write → beats held stable, no beat lost or duplicated. Beat sequence identical to the txReady_in=1 case.
- Read with no completion, TIMEOUT=16 → rspValid_out with rspErr_out=1 and data 32'hDEAD_DEAD exactly 16 cycles after the RD1 handshake.
- Completion with wrong tag, then one with the correct tag → first ignored, single response with the second's data.
- 32 reads → tag sequence 0…31, then 0. Reset asserted during RD1 → txValid_out=0 immediately, cmdReady_out=1 after release.

Source files
------------

// File: rtl/tlp_host_bfm.sv
// Host-side TLP initiator: turns register write/read commands into MWr32/MRd32
// TLPs and turns matching CplD TLPs back into single-cycle read responses.

package tlp_xcvr_pkg;
    typedef logic [3:0] Channel;
    typedef enum logic [1:0] {
        SOP_NONE = 2'd0,
        SOP_BAR0 = 2'd1,
        SOP_BAR1 = 2'd2,
        SOP_BAR2 = 2'd3
    } SopBar;
endpackage

module tlp_host_bfm #(
    parameter logic [15:0] REQ_ID   = 16'h0100,
    parameter logic [31:0] BAR_BASE = 32'h0000_0000,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                 pcieClk_in,
    input  logic                 reset_in,
    input  logic                 cmdWrite_in,
    input  tlp_xcvr_pkg::Channel cmdChan_in,
    input  logic [31:0]          cmdData_in,
    input  logic                 cmdValid_in,
    output logic                 cmdReady_out,
    output logic [31:0]          rspData_out,
    output logic                 rspErr_out,
    output logic                 rspValid_out,
    output logic [63:0]          txData_out,
    output logic                 txValid_out,
    input  logic                 txReady_in,
    output tlp_xcvr_pkg::SopBar  txSOP_out,
    output logic                 txEOP_out,
    input  logic [63:0]          rxData_in,
    input  logic                 rxValid_in,
    output logic                 rxReady_out,
    input  logic                 rxSOP_in,
    input  logic                 rxEOP_in
);
    import tlp_xcvr_pkg::*;

    localparam logic [31:0] MWR_DW0    = 32'h4000_0001;
    localparam logic [31:0] MRD_DW0    = 32'h0000_0001;
    localparam int          TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WR0, WR1, WR2, RD0, RD1, WAIT} req_state_t;
    typedef enum logic [1:0] {C0, C1, C2, CDROP} cpl_state_t;

    req_state_t    req_state, req_next;
    cpl_state_t    cpl_state, cpl_next;
    Channel        chan_q;
    logic [31:0]   data_q;
    logic [4:0]    tag_q, out_tag_q;
    logic [TW-1:0] timer_q;
    logic          rx_ready_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [31:0]   rsp_data_q;

    logic [31:0]   dw1, dw2;
    logic          timeout_hit;
    logic          cpl_match;
    logic [31:0]   cpl_data;
    logic          rx_beat, hdr_ok, id_ok;

    assign dw1         = {REQ_ID, 3'b000, tag_q, 4'h0, 4'hF};
    assign dw2         = (BAR_BASE + 32'({chan_q, 3'b000})) & 32'hFFFF_FFF8;
    assign timeout_hit = (req_state == WAIT) && (timer_q == TIMER_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            req_state <= IDLE;
            cpl_state <= C0;
        end else begin
            req_state <= req_next;
            cpl_state <= cpl_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req_next     = req_state;
        cmdReady_out = 1'b0;
        txValid_out  = 1'b0;
        txData_out   = '0;
        txSOP_out    = SOP_NONE;
        txEOP_out    = 1'b0;
        case (req_state)
            IDLE: begin
                cmdReady_out = rx_ready_q;
                if (cmdValid_in && rx_ready_q) req_next = cmdWrite_in ? WR0 : RD0;
            end
            WR0: begin
                txValid_out = 1'b1;
                txData_out  = {dw1, MWR_DW0};
                txSOP_out   = SOP_BAR0;
                if (txReady_in) req_next = WR1;
            end
            WR1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, dw2};
                if (txReady_in) req_next = WR2;
            end
            WR2: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, data_q};
                txEOP_out   = 1'b1;
                if (txReady_in) req_next = IDLE;
            end
            RD0: begin
                txValid_out = 1'b1;
                txData_out  = {dw1, MRD_DW0};
                txSOP_out   = SOP_BAR0;
                if (txReady_in) req_next = RD1;
            end
            RD1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, dw2};
                txEOP_out   = 1'b1;
                if (txReady_in) req_next = WAIT;
            end
            WAIT: begin
                if (cpl_match || timeout_hit) req_next = IDLE;
            end
            default: req_next = IDLE;
        endcase
    end

    // Completion parser; an SOP beat always restarts header parsing.
    assign rx_beat = rxValid_in && rx_ready_q;
    assign hdr_ok  = (rxData_in[31:24] == 8'h4A) && (rxData_in[9:0] == 10'd1) &&
                     (rxData_in[47:45] == 3'b000);
    assign id_ok   = (rxData_in[31:16] == REQ_ID) && (rxData_in[15:8] == {3'b000, out_tag_q}) &&
                     (req_state == WAIT);

    always_comb begin
        cpl_next  = cpl_state;
        cpl_match = 1'b0;
        cpl_data  = '0;
        if (rx_beat) begin
            if (rxSOP_in) begin
                if (rxEOP_in)    cpl_next = C0;
                else if (hdr_ok) cpl_next = C1;
                else             cpl_next = CDROP;
            end else begin
                case (cpl_state)
                    C0: cpl_next = C0;
                    C1: begin
                        if (id_ok && rxData_in[2]) begin
                            if (rxEOP_in) begin
                                cpl_match = 1'b1;
                                cpl_data  = rxData_in[63:32];
                                cpl_next  = C0;
                            end else begin
                                cpl_next = CDROP;
                            end
                        end else if (id_ok && !rxEOP_in) begin
                            cpl_next = C2;
                        end else begin
                            cpl_next = rxEOP_in ? C0 : CDROP;
                        end
                    end
                    C2: begin
                        if (rxEOP_in) begin
                            cpl_match = (req_state == WAIT);
                            cpl_data  = rxData_in[31:0];
                            cpl_next  = C0;
                        end else begin
                            cpl_next = CDROP;
                        end
                    end
                    CDROP: if (rxEOP_in) cpl_next = C0;
                    default: cpl_next = C0;
                endcase
            end
        end
    end

    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            rx_ready_q  <= 1'b0;
            chan_q      <= '0;
            data_q      <= '0;
            tag_q       <= '0;
            out_tag_q   <= '0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rx_ready_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (req_state == IDLE && cmdValid_in && rx_ready_q) begin
                chan_q <= cmdChan_in;
                data_q <= cmdData_in;
            end
            if (req_state == RD1 && txReady_in) begin
                out_tag_q <= tag_q;
                tag_q     <= tag_q + 5'd1;
                timer_q   <= '0;
            end else if (req_state == WAIT) begin
                timer_q <= timer_q + TW'(1);
            end
            // A completion landing on the timeout cycle takes priority.
            if (req_state == WAIT) begin
                if (cpl_match) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= cpl_data;
                end else if (timeout_hit) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= 32'hDEAD_DEAD;
                end
            end
        end
    end

    assign rxReady_out  = rx_ready_q;
    assign rspValid_out = rsp_valid_q;
    assign rspErr_out   = rsp_err_q;
    assign rspData_out  = rsp_data_q;

endmodule

// File: tb/tb_tlp_host_bfm.sv
// Scoreboard bench for tlp_host_bfm: expected TX beats and read responses are queued
// as commands are driven and compared by negedge monitors as the DUT produces them.

module tb_tlp_host_bfm;
    import tlp_xcvr_pkg::*;

    localparam logic [15:0] REQ_ID   = 16'h0100;
    localparam logic [31:0] BAR_BASE = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmdWrite_in;
    Channel      cmdChan_in;
    logic [31:0] cmdData_in;
    logic        cmdValid_in;
    logic        cmdReady_out;
    logic [31:0] rspData_out;
    logic        rspErr_out;
    logic        rspValid_out;
    logic [63:0] txData_out;
    logic        txValid_out;
    logic        txReady_in;
    SopBar       txSOP_out;
    logic        txEOP_out;
    logic [63:0] rxData_in;
    logic        rxValid_in;
    logic        rxReady_out;
    logic        rxSOP_in;
    logic        rxEOP_in;

    tlp_host_bfm #(.REQ_ID(REQ_ID), .BAR_BASE(BAR_BASE), .TIMEOUT(TIMEOUT)) dut (
        .pcieClk_in  (clk),
        .reset_in    (rst),
        .cmdWrite_in (cmdWrite_in),
        .cmdChan_in  (cmdChan_in),
        .cmdData_in  (cmdData_in),
        .cmdValid_in (cmdValid_in),
        .cmdReady_out(cmdReady_out),
        .rspData_out (rspData_out),
        .rspErr_out  (rspErr_out),
        .rspValid_out(rspValid_out),
        .txData_out  (txData_out),
        .txValid_out (txValid_out),
        .txReady_in  (txReady_in),
        .txSOP_out   (txSOP_out),
        .txEOP_out   (txEOP_out),
        .rxData_in   (rxData_in),
        .rxValid_in  (rxValid_in),
        .rxReady_out (rxReady_out),
        .rxSOP_in    (rxSOP_in),
        .rxEOP_in    (rxEOP_in)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        SopBar       sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    beat_t      tx_q[$];
    rsp_t       rsp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         rd_hs_cyc = 0;
    int         rsp_cyc   = 0;
    logic [4:0] model_tag = '0;
    logic       hold_pending = 1'b0;
    beat_t      hold_beat;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input logic [63:0] d, input SopBar s, input logic e);
        beat_t b;
        b.data = d;
        b.sop  = s;
        b.eop  = e;
        return b;
    endfunction

    function automatic logic [31:0] f_dw1(input logic [4:0] t);
        return {REQ_ID, 3'b000, t, 8'h0F};
    endfunction

    function automatic logic [31:0] f_dw2(input Channel ch);
        return BAR_BASE + {25'd0, ch, 3'b000};
    endfunction

    // TX monitor: beats must stay stable while stalled and match the scoreboard on handshake.
    always @(negedge clk) begin
        beat_t cur;
        beat_t want;
        rsp_t  rw;
        cur.data = txData_out;
        cur.sop  = txSOP_out;
        cur.eop  = txEOP_out;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                n_checks++;
                if (!txValid_out || cur !== hold_beat)
                    $display("FAIL tx_hold: got valid=%0b data=%h sop=%0d eop=%0b, want held data=%h sop=%0d eop=%0b",
                             txValid_out, cur.data, cur.sop, cur.eop, hold_beat.data, hold_beat.sop, hold_beat.eop);
                else n_pass++;
            end
            if (txValid_out && txReady_in) begin
                hold_pending = 1'b0;
                n_checks++;
                if (tx_q.size() == 0) begin
                    $display("FAIL tx_unexpected: got data=%h sop=%0d eop=%0b, want no beat", cur.data, cur.sop, cur.eop);
                end else begin
                    want = tx_q.pop_front();
                    if (cur !== want)
                        $display("FAIL tx_beat: got data=%h sop=%0d eop=%0b, want data=%h sop=%0d eop=%0b",
                                 cur.data, cur.sop, cur.eop, want.data, want.sop, want.eop);
                    else n_pass++;
                end
                if (txEOP_out) rd_hs_cyc = cyc + 1;
            end else if (txValid_out) begin
                hold_pending = 1'b1;
                hold_beat    = cur;
            end else begin
                hold_pending = 1'b0;
            end
            if (rspValid_out) begin
                n_checks++;
                rsp_cyc = cyc;
                if (rsp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got data=%h err=%0b, want no response", rspData_out, rspErr_out);
                end else begin
                    rw = rsp_q.pop_front();
                    if (rspData_out !== rw.data || rspErr_out !== rw.err)
                        $display("FAIL rsp: got data=%h err=%0b, want data=%h err=%0b",
                                 rspData_out, rspErr_out, rw.data, rw.err);
                    else n_pass++;
                end
            end
        end
    end

    task automatic push_write(input Channel ch, input logic [31:0] d);
        tx_q.push_back(mk({f_dw1(model_tag), 32'h4000_0001}, SOP_BAR0, 1'b0));
        tx_q.push_back(mk({32'h0, f_dw2(ch)}, SOP_NONE, 1'b0));
        tx_q.push_back(mk({32'h0, d}, SOP_NONE, 1'b1));
    endtask

    task automatic push_read(input Channel ch, output logic [4:0] t);
        t = model_tag;
        tx_q.push_back(mk({f_dw1(model_tag), 32'h0000_0001}, SOP_BAR0, 1'b0));
        tx_q.push_back(mk({32'h0, f_dw2(ch)}, SOP_NONE, 1'b1));
        model_tag = model_tag + 5'd1;
    endtask

    task automatic send_cmd(input logic wr, input Channel ch, input logic [31:0] d);
        bit got;
        got = 1'b0;
        cmdWrite_in = wr;
        cmdChan_in  = ch;
        cmdData_in  = d;
        cmdValid_in = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmdReady_out) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL cmd_accept: got no cmdReady_out in 200 cycles, want acceptance");
        end
        @(posedge clk); #1;
        cmdValid_in = 1'b0;
    endtask

    task automatic wait_tx_drain(input bit rnd_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
            if (tx_q.size() == 0) done = 1'b1;
            else if (rnd_ready) txReady_in = 1'($urandom_range(0, 1));
        end
        txReady_in = 1'b1;
        if (!done) begin
            n_checks++;
            $display("FAIL tx_drain: got %0d beats still pending, want 0", tx_q.size());
            tx_q.delete();
        end
    endtask

    task automatic wait_rsp();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (rsp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL rsp_wait: got %0d responses still pending, want 0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic send_cpl(input logic [7:0] tag, input logic [6:0] la, input logic [31:0] d,
                            input logic [2:0] st);
        logic [31:0] dw2;
        dw2 = {REQ_ID, tag, 1'b0, la};
        rxValid_in = 1'b1;
        rxSOP_in   = 1'b1;
        rxEOP_in   = 1'b0;
        rxData_in  = {16'h0000, st, 1'b0, 12'd4, 32'h4A00_0001};
        @(posedge clk); #1;
        rxSOP_in = 1'b0;
        if (la[2]) begin
            rxData_in = {d, dw2};
            rxEOP_in  = 1'b1;
        end else begin
            rxData_in = {32'h0, dw2};
            @(posedge clk); #1;
            rxData_in = {32'h0, d};
            rxEOP_in  = 1'b1;
        end
        @(posedge clk); #1;
        rxValid_in = 1'b0;
        rxEOP_in   = 1'b0;
        rxData_in  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({txValid_out, txEOP_out, txSOP_out, cmdReady_out, rspValid_out, rspErr_out, rxReady_out} !== 8'h00)
            $display("FAIL reset_ctrl: got valid=%0b eop=%0b sop=%0d cmdReady=%0b rspValid=%0b rspErr=%0b rxReady=%0b, want all 0",
                     txValid_out, txEOP_out, txSOP_out, cmdReady_out, rspValid_out, rspErr_out, rxReady_out);
        else n_pass++;
        n_checks++;
        if (txData_out !== 64'h0 || rspData_out !== 32'h0)
            $display("FAIL reset_data: got txData=%h rspData=%h, want 0 and 0", txData_out, rspData_out);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rxReady_out !== 1'b1 || cmdReady_out !== 1'b1)
            $display("FAIL reset_release: got rxReady=%0b cmdReady=%0b, want 1 and 1", rxReady_out, cmdReady_out);
        else n_pass++;
    endtask

    task automatic test_write();
        txReady_in = 1'b1;
        tx_q.push_back(mk(64'h0100_000F_4000_0001, SOP_BAR0, 1'b0));
        tx_q.push_back(mk(64'h0000_0000_0000_0018, SOP_NONE, 1'b0));
        tx_q.push_back(mk(64'h0000_0000_1234_5678, SOP_NONE, 1'b1));
        send_cmd(1'b1, 4'd3, 32'h1234_5678);
        n_checks++;
        if (txValid_out !== 1'b1 || txSOP_out !== SOP_BAR0)
            $display("FAIL write_latency: got valid=%0b sop=%0d one cycle after accept, want 1 and %0d",
                     txValid_out, txSOP_out, SOP_BAR0);
        else n_pass++;
        wait_tx_drain(1'b0);
        n_checks++;
        if (cmdReady_out !== 1'b1)
            $display("FAIL write_done_ready: got cmdReady=%0b, want 1", cmdReady_out);
        else n_pass++;
    endtask

    task automatic test_read_cpl();
        tx_q.push_back(mk(64'h0100_000F_0000_0001, SOP_BAR0, 1'b0));
        tx_q.push_back(mk(64'h0000_0000_0000_0028, SOP_NONE, 1'b1));
        model_tag = model_tag + 5'd1;
        send_cmd(1'b0, 4'd5, 32'h0);
        wait_tx_drain(1'b0);
        n_checks++;
        if (cmdReady_out !== 1'b0)
            $display("FAIL wait_ready: got cmdReady=%0b while read outstanding, want 0", cmdReady_out);
        else n_pass++;
        rsp_q.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
        send_cpl(8'h00, 7'h28, 32'hCAFE_F00D, 3'b000);
        wait_rsp();
        n_checks++;
        if (cmdReady_out !== 1'b1)
            $display("FAIL read_done_ready: got cmdReady=%0b, want 1", cmdReady_out);
        else n_pass++;
        // Second read carries tag 1; its completion uses the upper-half data path.
        tx_q.push_back(mk(64'h0100_010F_0000_0001, SOP_BAR0, 1'b0));
        tx_q.push_back(mk(64'h0000_0000_0000_0028, SOP_NONE, 1'b1));
        model_tag = model_tag + 5'd1;
        send_cmd(1'b0, 4'd5, 32'h0);
        wait_tx_drain(1'b0);
        rsp_q.push_back('{data: 32'h5555_AAAA, err: 1'b0});
        send_cpl(8'h01, 7'h2C, 32'h5555_AAAA, 3'b000);
        wait_rsp();
    endtask

    task automatic test_backpressure();
        txReady_in = 1'b0;
        push_write(4'd9, 32'hA5A5_0F0F);
        send_cmd(1'b1, 4'd9, 32'hA5A5_0F0F);
        wait_tx_drain(1'b1);
        txReady_in = 1'b0;
        push_write(4'd15, 32'h0BAD_BEEF);
        send_cmd(1'b1, 4'd15, 32'h0BAD_BEEF);
        wait_tx_drain(1'b1);
    endtask

    task automatic test_timeout();
        logic [4:0] t;
        push_read(4'd2, t);
        rsp_q.push_back('{data: 32'hDEAD_DEAD, err: 1'b1});
        send_cmd(1'b0, 4'd2, 32'h0);
        wait_tx_drain(1'b0);
        wait_rsp();
        n_checks++;
        if (rsp_cyc - rd_hs_cyc != TIMEOUT)
            $display("FAIL timeout_latency: got %0d cycles after RD1 handshake (tag %0d), want %0d",
                     rsp_cyc - rd_hs_cyc, t, TIMEOUT);
        else n_pass++;
    endtask

    task automatic test_wrong_tag();
        logic [4:0] t;
        push_read(4'd6, t);
        send_cmd(1'b0, 4'd6, 32'h0);
        wait_tx_drain(1'b0);
        rsp_q.push_back('{data: 32'h2222_2222, err: 1'b0});
        send_cpl({3'b000, t + 5'd1}, 7'h30, 32'h1111_1111, 3'b000);
        send_cpl({3'b000, t}, 7'h30, 32'h2222_2222, 3'b000);
        wait_rsp();
        // A completion arriving while idle must be dropped silently.
        send_cpl({3'b000, t}, 7'h30, 32'h3333_3333, 3'b000);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (cmdReady_out !== 1'b1 || rsp_q.size() != 0)
            $display("FAIL stray_cpl: got cmdReady=%0b pending=%0d, want 1 and 0", cmdReady_out, rsp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic [4:0] t;
        txReady_in = 1'b1;
        push_read(4'd7, t);
        send_cmd(1'b0, 4'd7, 32'h0);
        @(posedge clk); #1;
        txReady_in = 1'b0;
        n_checks++;
        if (txValid_out !== 1'b1 || txEOP_out !== 1'b1)
            $display("FAIL rd1_reached: got valid=%0b eop=%0b, want 1 and 1", txValid_out, txEOP_out);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (txValid_out !== 1'b0 || txEOP_out !== 1'b0 || cmdReady_out !== 1'b0)
            $display("FAIL reset_mid_tlp: got valid=%0b eop=%0b cmdReady=%0b, want 0 0 0",
                     txValid_out, txEOP_out, cmdReady_out);
        else n_pass++;
        tx_q.delete();
        rsp_q.delete();
        model_tag = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        txReady_in = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cmdReady_out !== 1'b1)
            $display("FAIL reset_mid_release: got cmdReady=%0b, want 1", cmdReady_out);
        else n_pass++;
    endtask

    task automatic test_tag_wrap();
        logic [4:0] t;
        logic [31:0] d;
        for (int i = 0; i < 33; i++) begin
            push_read(i[3:0], t);
            send_cmd(1'b0, i[3:0], 32'h0);
            wait_tx_drain(1'b0);
            d = 32'h7000_0000 + i;
            rsp_q.push_back('{data: d, err: 1'b0});
            send_cpl({3'b000, t}, i[0] ? 7'h04 : 7'h00, d, 3'b000);
            wait_rsp();
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmdWrite_in = 1'b0;
        cmdChan_in  = '0;
        cmdData_in  = '0;
        cmdValid_in = 1'b0;
        txReady_in  = 1'b0;
        rxData_in   = '0;
        rxValid_in  = 1'b0;
        rxSOP_in    = 1'b0;
        rxEOP_in    = 1'b0;
        test_reset();
        test_write();
        test_read_cpl();
        test_backpressure();
        test_timeout();
        test_wrong_tag();
        test_reset_mid_read();
        test_tag_wrap();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running at 2ms, want completion");
        $fatal(1);
    end

endmodule
